// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit active-low 7-segment driver with per-frame input snapshot.
// Optional `define LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DIG_3,
    input  logic [3:0] DIG_2,
    input  logic [3:0] DIG_1,
    input  logic [3:0] DIG_0,
    input  logic [3:0] BLANK,
    input  logic [3:0] DP,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP_N
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW:0]   GUARD_W = (CW + 1)'(GUARD);

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic            valid;
    logic [3:0][3:0] snap_dig;
    logic [3:0]      snap_blank;
    logic [3:0]      snap_dp;

    logic            tick;
    logic            in_guard;
    logic [3:0]      cur_dig;
    logic            lz;
    logic            dark;
    logic [6:0]      glyph;
    logic [3:0]      next_an;
    logic [6:0]      next_seg;
    logic            next_dp_n;

    assign tick     = (cnt == CNT_MAX);
    assign in_guard = ({1'b0, cnt} < GUARD_W);

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lz = 1'b0;
        case (idx)
            2'd3:    lz = (snap_dig[3] == 4'h0);
            2'd2:    lz = (snap_dig[3] == 4'h0) && (snap_dig[2] == 4'h0);
            2'd1:    lz = (snap_dig[3] == 4'h0) && (snap_dig[2] == 4'h0) && (snap_dig[1] == 4'h0);
            default: lz = 1'b0;
        endcase
    end
`else
    assign lz = 1'b0;
`endif

    always_comb begin
        cur_dig = snap_dig[idx];
        dark    = snap_blank[idx] | lz;
        glyph   = 7'h7F;
        case (cur_dig)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'h7F;
        endcase

        next_an   = 4'hF;
        next_seg  = 7'h7F;
        next_dp_n = 1'b1;
        if (valid) begin
            // Segments already show the new digit during the guard; only anodes stay dark.
            next_an   = in_guard ? 4'hF : ~(4'b0001 << idx);
            next_seg  = dark ? 7'h7F : glyph;
            next_dp_n = dark ? 1'b1 : ~snap_dp[idx];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            idx        <= 2'd3;
            valid      <= 1'b0;
            snap_dig   <= '0;
            snap_blank <= '0;
            snap_dp    <= '0;
            AN         <= 4'hF;
            SEG        <= 7'h7F;
            DP_N       <= 1'b1;
        end else begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            AN   <= next_an;
            SEG  <= next_seg;
            DP_N <= next_dp_n;
            if (tick) begin
                idx   <= idx + 2'd1;
                valid <= 1'b1;
                // Snapshot at the frame boundary so a whole frame shows consistent data.
                if (idx == 2'd3) begin
                    snap_dig   <= {DIG_3, DIG_2, DIG_1, DIG_0};
                    snap_blank <= BLANK;
                    snap_dp    <= DP;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver with two parameter sets
// (SCAN_DIV=4/GUARD=1 and SCAN_DIV=3/GUARD=0) against a cycle-arithmetic model.
module tb_seg_scan_driver;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] dig [4];
    logic [3:0] blank_in;
    logic [3:0] dp_in;

    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dpn0, dpn1;
    logic [11:0] got [2];

    int tests = 0;
    int fails = 0;
    int n = 0;
    logic [11:0] expv [2];

    logic [3:0] s_dig [2][4];
    logic [3:0] s_blank [2];
    logic [3:0] s_dp [2];

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 CLK = ~CLK;

    seg_scan_driver #(.SCAN_DIV(4), .GUARD(1)) u_dut0 (
        .CLK(CLK), .RST(RST),
        .DIG_3(dig[3]), .DIG_2(dig[2]), .DIG_1(dig[1]), .DIG_0(dig[0]),
        .BLANK(blank_in), .DP(dp_in),
        .AN(an0), .SEG(seg0), .DP_N(dpn0));

    seg_scan_driver #(.SCAN_DIV(3), .GUARD(0)) u_dut1 (
        .CLK(CLK), .RST(RST),
        .DIG_3(dig[3]), .DIG_2(dig[2]), .DIG_1(dig[1]), .DIG_0(dig[0]),
        .BLANK(blank_in), .DP(dp_in),
        .AN(an1), .SEG(seg1), .DP_N(dpn1));

    assign got[0] = {an0, seg0, dpn0};
    assign got[1] = {an1, seg1, dpn1};

    function automatic int sd_of(int inst);
        return (inst == 0) ? 4 : 3;
    endfunction

    function automatic int guard_of(int inst);
        return (inst == 0) ? 1 : 0;
    endfunction

    // Expected {AN,SEG,DP_N} once e edges have elapsed since reset release.
    function automatic logic [11:0] model(int inst, int e);
        int sd = sd_of(inst);
        int i, c;
        logic dark;
        logic [6:0] seg;
        logic dpn;
        logic [3:0] an;
        if (e < sd) return {4'hF, 7'h7F, 1'b1};
        i = ((e / sd) - 1) % 4;
        c = e % sd;
        dark = s_blank[inst][i];
`ifdef LEADING_ZERO_BLANK_EN
        if (i >= 1) begin
            logic allz = 1'b1;
            for (int j = i; j <= 3; j++) if (s_dig[inst][j] != 4'h0) allz = 1'b0;
            if (allz) dark = 1'b1;
        end
`endif
        seg = dark ? 7'h7F : GLYPH[s_dig[inst][i]];
        dpn = dark ? 1'b1 : ~s_dp[inst][i];
        an  = (c < guard_of(inst)) ? 4'hF : ~(4'b0001 << i);
        return {an, seg, dpn};
    endfunction

    task automatic step();
        @(posedge CLK);
        n++;
        for (int k = 0; k < 2; k++) begin
            expv[k] = model(k, n - 1);
            if ((n % sd_of(k)) == 0 && ((n / sd_of(k)) % 4) == 1) begin
                for (int j = 0; j < 4; j++) s_dig[k][j] = dig[j];
                s_blank[k] = blank_in;
                s_dp[k]    = dp_in;
            end
        end
        #1;
    endtask

    task automatic clear_model();
        n = 0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) s_dig[k][j] = 4'h0;
            s_blank[k] = 4'h0;
            s_dp[k]    = 4'h0;
        end
    endtask

    task automatic set_inputs(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic [3:0] b, input logic [3:0] p);
        dig[3] = d3; dig[2] = d2; dig[1] = d1; dig[0] = d0;
        blank_in = b;
        dp_in = p;
    endtask

    task automatic test_reset();
        set_inputs(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0);
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (got[k] !== 12'hFFF) begin
                fails++;
                $display("[TB] FAIL reset_hold inst%0d: got %h want fff", k, got[k]);
            end
        end
        clear_model();
        RST = 1'b0;
        repeat (6) begin
            step();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got[k] !== expv[k]) begin
                    fails++;
                    $display("[TB] FAIL reset_release inst%0d n=%0d: got %h want %h", k, n, got[k], expv[k]);
                end
            end
        end
    endtask

    task automatic run_checked(input int cycles, input string name);
        repeat (cycles) begin
            step();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (got[k] !== expv[k]) begin
                    fails++;
                    $display("[TB] FAIL %s inst%0d n=%0d: got %h want %h", name, k, n, got[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_scan_order();
        set_inputs(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0);
        run_checked(40, "scan_order");
    endtask

    task automatic test_snapshot();
        run_checked(6, "snapshot_pre");
        dig[0] = 4'h8;
        run_checked(40, "snapshot");
    endtask

    task automatic test_hex_dp_blank();
        set_inputs(4'h7, 4'hC, 4'h5, 4'hB, 4'b0010, 4'b0001);
        run_checked(40, "hex_dp_blank");
    endtask

    task automatic test_leading_zero();
        set_inputs(4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 4'b1111);
        run_checked(40, "leading_zero");
        set_inputs(4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0);
        run_checked(40, "leading_zero_inner");
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            set_inputs(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (($urandom % 3) == 0) dig[3] = 4'h0;
            run_checked($urandom_range(1, 20), "random");
        end
    endtask

    task automatic test_mid_reset();
        int budget = 64;
        while (budget > 0 && expv[0][11:8] !== 4'hB) begin
            step();
            budget--;
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("[TB] FAIL mid_reset_find: got no AN=B slot want one within 64 cycles");
        end
        #2;
        RST = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (got[k] !== 12'hFFF) begin
                fails++;
                $display("[TB] FAIL mid_reset_async inst%0d: got %h want fff", k, got[k]);
            end
        end
        repeat (2) @(posedge CLK);
        #1;
        clear_model();
        RST = 1'b0;
        run_checked(30, "mid_reset_restart");
    endtask

    initial begin
        set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        clear_model();
        expv[0] = 12'hFFF;
        expv[1] = 12'hFFF;
        test_reset();
        test_scan_order();
        test_snapshot();
        test_hex_dp_blank();
        test_leading_zero();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
